secded_mem_sequencer: RTL and testbench
=======================================

// Module: secded_mem_sequencer
// PURPOSE
// - Hardware engine for the program-2 task: walks NUM_WORDS 16-bit Hamming SEC-DED codewords in data memory.
// - Decodes and corrects each word, then writes the 16-bit result back to a destination area.
// - Sits beside data_mem as an alternate memory master. Started by start, reports completion on halt (same pulse/level protocol as TopLevel).
// PARAMETERS
// - NUM_WORDS  15    number of codewords processed per run (1..127)
// - SRC_BASE   30    byte address of the first codeword (low byte at SRC_BASE+2i, high byte at +2i+1)
// - DST_BASE   0     byte address of the first result (low byte at DST_BASE+2i, high byte at +2i+1)
// - AW         8     data-memory address width
// PORTS
// - CLK       in   1   system clock, all state on rising edge
// - rst_n     in   1   asynchronous active-low reset
// - start     in   1   run request, sampled high for >=1 cycle
// - halt      out  1   high while in DONE; run complete
// - mem_addr  out  AW  data-memory byte address
// - mem_rdata in   8   data-memory read data (combinational read of mem_addr)
// - mem_we    out  1   data-memory write enable, written at next rising CLK
// - mem_wdata out  8   data-memory write data
// - n_single  out  8   count of single-error words in this run
// - n_double  out  8   count of double-error words in this run
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, word index i=0, lo/hi latches=0.
//   All outputs 0: halt, mem_addr, mem_we, mem_wdata, n_single, n_double.
// - FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
//   - IDLE/DONE --start--> RD_LO. On this transition i, n_single and n_double clear. halt drops in the same edge.
//   - RD_LO: mem_addr=SRC_BASE+2i, lo<=mem_rdata -> RD_HI.
//   - RD_HI: mem_addr=SRC_BASE+2i+1, hi<=mem_rdata -> WR_LO.
//   - WR_LO: mem_addr=DST_BASE+2i, mem_we=1, mem_wdata=res[7:0] -> WR_HI.
//   - WR_HI: mem_addr=DST_BASE+2i+1, mem_we=1, mem_wdata=res[15:8]; update counters.
//     If i==NUM_WORDS-1 -> DONE, else i<=i+1 -> RD_LO.
//   - DONE: halt=1, mem_we=0; counters held until the next start.
// - Latency: 4 cycles per word. halt rises 4*NUM_WORDS+1 edges after start is sampled (61 for the default).
// - start is ignored in RD_*/WR_*. mem_we is 0 in every state except WR_LO/WR_HI.
// - Codeword bit map, w={hi,lo}: bit0=p0, 1=p1, 2=p2, 3=d1, 4=p4, 5..7=d2..d4, 8=p8, 9..15=d5..d11.
// - Decode (combinational on {hi,lo}):
//   - s[3:0] = XOR of indices k (1..15) where w[k]=1.
//   - P = ^w (16-bit overall parity).
//   - P==0, s==0: no error. res={2'b00,3'b000,d[11:1]}.
//   - P==1: single error. Flip bit s (s==0 means p0; data unaffected), then extract d. res={2'b01,3'b000,d}; n_single++.
//   - P==0, s!=0: double error. No correction; d taken raw. res={2'b10,3'b000,d}; n_double++.
//   - Counters saturate at 8'hFF.
// - Reset mid-run: abort immediately. Destination bytes already written stay in memory; halt stays 0 until a full run completes.
// - Source and destination areas must not overlap (a caller rule, not checked).
// STRUCTURE
// - Package secded_pkg: state enum state_t; localparam bit positions of p0/p1/p2/p4/p8; result flag encodings (FLAG_NONE=2'b00, FLAG_SGL=2'b01, FLAG_DBL=2'b10).
// - Sub-module secded_dec16: purely combinational.
//   - Input w[15:0]. Outputs res[15:0], sgl, dbl.
//   - Reusable by the prog1 encoder checker.
// - Top level holds the FSM, word-index counter, lo/hi latches, address mux and error counters.
// TESTING
// - Codeword 0x0000 at SRC, NUM_WORDS=1 -> DST bytes 0x00,0x00; n_single=0; n_double=0; halt at edge 5.
// - Data 0x7FF encoded as 0xFFFF -> result 0x07FF. The same word with bit 9 flipped (0xFDFF) -> 0x47FF, n_single=1.
// - Word 0x0008 (d1 flipped from 0x0000) -> 0x4000. Word 0x0001 (p0 flipped) -> 0x4000.
// - Word 0x0028 (bits 3 and 5 flipped) -> 0x8003, n_double=1, no correction applied.
// - 15 random words from the prog2_tb generator (75% single, ~25% double) -> every result matches the golden model.
//   Counters equal the injected counts. halt at edge 61. start pulses during the run are ignored.
// - rst_n low for 1 cycle in RD_HI of word 7 -> outputs 0 at once. A new start runs all 15 words and rewrites DST correctly.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared definitions for the SEC-DED memory sequencer.
//   state_t       : sequencer FSM states
//   P*_POS        : bit positions of the parity bits inside a 16-bit codeword
//   FLAG_*        : two-bit status placed in res[15:14] by the decoder
//   sat_inc8      : saturating 8-bit increment used by the error counters
package secded_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_SGL  = 2'b01;
    localparam logic [1:0] FLAG_DBL  = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/secded_dec16.sv
// Combinational Hamming SEC-DED decoder for one 16-bit codeword.
//   w   in  16  codeword {hi,lo}; bit0 is overall parity, bits 1/2/4/8 are
//               Hamming parity, the remaining 11 bits carry data d1..d11
//   res out 16  {flag[1:0], 3'b000, d[11:1]}
//   sgl out 1   single error detected (and corrected)
//   dbl out 1   double error detected (data passed through raw)
module secded_dec16
    import secded_pkg::*;
(
    input  logic [15:0] w,
    output logic [15:0] res,
    output logic        sgl,
    output logic        dbl
);

    logic [3:0]  syn;
    logic        par;
    logic [15:0] corr;
    logic [10:0] data;
    logic [1:0]  flag;
    logic [3:0]  flip_pos;

    always_comb begin
        syn      = 4'd0;
        par      = ^w;
        corr     = w;
        sgl      = 1'b0;
        dbl      = 1'b0;
        flag     = FLAG_NONE;
        data     = 11'd0;
        flip_pos = 4'd0;

        for (int k = 1; k < 16; k++) begin
            if (w[k]) syn = syn ^ 4'(k);
        end

        if (par) begin
            // A zero syndrome with odd parity points at the overall parity bit.
            flip_pos       = (syn == 4'd0) ? 4'(P0_POS) : syn;
            corr[flip_pos] = ~corr[flip_pos];
            sgl            = 1'b1;
            flag           = FLAG_SGL;
        end else if (syn != 4'd0) begin
            dbl  = 1'b1;
            flag = FLAG_DBL;
        end

        // Gather the non-parity positions in ascending order: d1 lands in data[0].
        begin
            int j;
            j = 0;
            for (int k = 1; k < 16; k++) begin
                if (k != P1_POS && k != P2_POS && k != P4_POS && k != P8_POS) begin
                    data[j] = corr[k];
                    j++;
                end
            end
        end

        res = {flag, 3'b000, data};
    end

endmodule

// File: rtl/secded_mem_sequencer.sv
// Memory-master engine that walks NUM_WORDS SEC-DED codewords starting at
// SRC_BASE, decodes/corrects each, and writes the 16-bit results to DST_BASE.
//   CLK       in   1   clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   run request (honoured in IDLE and DONE only)
//   halt      out  1   high while the run is complete (DONE)
//   mem_addr  out  AW  data-memory byte address
//   mem_rdata in   8   combinational read data for mem_addr
//   mem_we    out  1   write enable, memory writes on next rising CLK
//   mem_wdata out  8   write data
//   n_single  out  8   saturating count of single-error words this run
//   n_double  out  8   saturating count of double-error words this run
module secded_mem_sequencer
    import secded_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          start,
    output logic          halt,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    output logic [7:0]    n_single,
    output logic [7:0]    n_double
);

    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);
    localparam logic [6:0]    LAST_IDX = 7'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  nsgl_q, nsgl_d;
    logic [7:0]  ndbl_q, ndbl_d;

    logic [AW-1:0] word_off;
    logic [15:0]   dec_res;
    logic          dec_sgl;
    logic          dec_dbl;

    assign word_off = AW'({idx_q, 1'b0});

    secded_dec16 u_dec (
        .w   ({hi_q, lo_q}),
        .res (dec_res),
        .sgl (dec_sgl),
        .dbl (dec_dbl)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 7'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            nsgl_q  <= 8'd0;
            ndbl_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            nsgl_q  <= nsgl_d;
            ndbl_q  <= ndbl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        nsgl_d    = nsgl_q;
        ndbl_d    = ndbl_q;
        halt      = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                halt = (state_q == S_DONE);
                if (start) begin
                    // Counters stay visible after a run until the next one begins.
                    state_d = S_RD_LO;
                    idx_d   = 7'd0;
                    nsgl_d  = 8'd0;
                    ndbl_d  = 8'd0;
                end
            end
            S_RD_LO: begin
                mem_addr = SRC_A + word_off;
                lo_d     = mem_rdata;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr = SRC_A + word_off + AW'(1);
                hi_d     = mem_rdata;
                state_d  = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr  = DST_A + word_off;
                mem_we    = 1'b1;
                mem_wdata = dec_res[7:0];
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr  = DST_A + word_off + AW'(1);
                mem_we    = 1'b1;
                mem_wdata = dec_res[15:8];
                if (dec_sgl) nsgl_d = sat_inc8(nsgl_q);
                if (dec_dbl) ndbl_d = sat_inc8(ndbl_q);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = S_RD_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign n_single = nsgl_q;
    assign n_double = ndbl_q;

endmodule

// File: tb/tb_secded_mem_sequencer.sv
module tb_secded_mem_sequencer;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    // Directed codewords and their hand-decoded results.
    localparam logic [15:0] SRC_W [NW] = '{
        16'h0000, 16'hFFFF, 16'hFDFF, 16'h0008, 16'h0001,
        16'h0028, 16'hFFFE, 16'h7FFF, 16'h0018, 16'h8000,
        16'hC000, 16'h000F, 16'h002F, 16'h000E, 16'h0003
    };
    localparam logic [15:0] EXP_R [NW] = '{
        16'h0000, 16'h07FF, 16'h47FF, 16'h4000, 16'h4000,
        16'h8003, 16'h47FF, 16'h47FF, 16'h8001, 16'h4000,
        16'h8600, 16'h0001, 16'h4001, 16'h4001, 16'h8000
    };
    localparam int EXP_SGL = 8;
    localparam int EXP_DBL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] n_single;
    logic [7:0] n_double;

    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    secded_mem_sequencer dut (
        .CLK       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .n_single  (n_single),
        .n_double  (n_double)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write the DUT presents must match the next queued one.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h", mem_addr, mem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write actual=0x%0h expected=0x%0h", {mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_expected();
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back({8'(DST + 2*i),     EXP_R[i][7:0]});
            exp_q.push_back({8'(DST + 2*i + 1), EXP_R[i][15:8]});
        end
    endtask

    task automatic check_dst(input string tag);
        for (int i = 0; i < NW; i++)
            chk({tag, "_dst"}, {16'd0, mem[DST + 2*i + 1], mem[DST + 2*i]}, {16'd0, EXP_R[i]});
    endtask

    // Full run: start sampled at edge 1, stray start pulses at edges 10 and 40.
    task automatic full_run(input string tag);
        int edges;
        edges = 0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                start = 1'b0;
                chk({tag, "_halt_drop"}, {31'd0, halt}, 32'd0);
                chk({tag, "_nsgl_clr"}, {24'd0, n_single}, 32'd0);
                chk({tag, "_ndbl_clr"}, {24'd0, n_double}, 32'd0);
            end
            if (edges == 10 || edges == 40) start = 1'b1;
            if (edges == 11 || edges == 41) start = 1'b0;
            if (halt) break;
        end
        start = 1'b0;
        chk({tag, "_halt_edge"}, edges, 32'd61);
        chk({tag, "_n_single"}, {24'd0, n_single}, EXP_SGL);
        chk({tag, "_n_double"}, {24'd0, n_double}, EXP_DBL);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        check_dst(tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_halt_held"}, {31'd0, halt}, 32'd1);
        chk({tag, "_we_done"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_nsgl_held"}, {24'd0, n_single}, EXP_SGL);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset state
        #2;
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_nsgl", {24'd0, n_single}, 32'd0);
        chk("rst_ndbl", {24'd0, n_double}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NW; i++) begin
            poke(8'(SRC + 2*i),     SRC_W[i][7:0]);
            poke(8'(SRC + 2*i + 1), SRC_W[i][15:8]);
        end
        for (int i = 0; i < 2*NW; i++) poke(8'(DST + i), 8'h55);

        full_run("run1");

        // Second run from DONE, aborted by reset in RD_HI of word 7.
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("run2_halt_drop", {31'd0, halt}, 32'd0);
        guard = 0;
        while (mem_addr != 8'(SRC + 15) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("run2_reach_w7_rdhi", {31'd0, (guard < 100)}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_halt", {31'd0, halt}, 32'd0);
        chk("abort_addr", {24'd0, mem_addr}, 32'd0);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        chk("abort_nsgl", {24'd0, n_single}, 32'd0);
        chk("abort_ndbl", {24'd0, n_double}, 32'd0);
        chk("abort_pending_writes", exp_q.size(), 32'd16);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_halt", {31'd0, halt}, 32'd0);

        for (int i = 0; i < 2*NW; i++) poke(8'(DST + i), 8'hAA);
        full_run("run3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
